// File: rtl/speed_pkg.sv
// Shared constants, FSM state type and helpers for the speed level meter
// and the downstream speed-LED decoder.
package speed_pkg;

    localparam int unsigned LEVEL_W   = 3;
    localparam int unsigned LEVEL_MAX = 7;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Floor log2; LEVEL_STEP is a power of two, so this is exact.
    function automatic int unsigned log2_int(input int unsigned v);
        int unsigned r = 0;
        int unsigned x = v;
        while (x > 1) begin
            x = x >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for an asynchronous sensor line, plus a third flop
// for a one-cycle rising-edge strobe.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise_c
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/speed_level_meter.sv
// Counts wheel pulses over back-to-back gate windows and reports the count,
// a quantised speed level and a motion flag once per window.
module speed_level_meter
    import speed_pkg::*;
#(
    parameter int unsigned GATE_CYCLES  = 1000,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned LEVEL_STEP   = 4,
    parameter int unsigned STOP_WINDOWS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               wheel,
    output logic [LEVEL_W-1:0] level,
    output logic               moving,
    output logic               valid,
    output logic [CNT_W-1:0]   pulse_cnt
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned SHIFT  = log2_int(LEVEL_STEP);
    localparam int unsigned ZERO_W = $clog2(STOP_WINDOWS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q;
    state_t              state_d;
    logic [GATE_W-1:0]   gate_q;
    logic [CNT_W-1:0]    win_cnt_q;
    logic [ZERO_W-1:0]   zero_q;
    logic                rise_c;
    logic                close_c;
    logic [CNT_W-1:0]    quot_c;
    logic [LEVEL_W-1:0]  level_c;
    logic [ZERO_W-1:0]   zero_inc_c;

    pulse_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .raw    (wheel),
        .rise_c (rise_c)
    );

    // Next state; a window closes only if run is still high on its terminal cycle.
    always_comb begin
        state_d = state_q;
        close_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = MEASURE;
            end
            MEASURE: begin
                close_c = run && (gate_q == GATE_W'(GATE_CYCLES - 1));
                if (!run) state_d = IDLE;
            end
        endcase
    end

    // Level quantisation with clamp, and saturating empty-window count.
    always_comb begin
        quot_c     = win_cnt_q >> SHIFT;
        level_c    = (quot_c > CNT_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX) : LEVEL_W'(quot_c);
        zero_inc_c = (zero_q == ZERO_W'(STOP_WINDOWS)) ? zero_q : zero_q + ZERO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Gate/pulse counting and registered window results; idle or abort clears all.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || !run) begin
            gate_q    <= '0;
            win_cnt_q <= '0;
            zero_q    <= '0;
            level     <= '0;
            moving    <= 1'b0;
            valid     <= 1'b0;
            pulse_cnt <= '0;
        end else if (close_c) begin
            gate_q    <= '0;
            win_cnt_q <= CNT_W'(rise_c);
            pulse_cnt <= win_cnt_q;
            valid     <= 1'b1;
            if (win_cnt_q != '0) begin
                level  <= level_c;
                moving <= 1'b1;
                zero_q <= '0;
            end else begin
                zero_q <= zero_inc_c;
                if (zero_inc_c == ZERO_W'(STOP_WINDOWS)) begin
                    level  <= '0;
                    moving <= 1'b0;
                end
            end
        end else begin
            gate_q <= gate_q + GATE_W'(1);
            valid  <= 1'b0;
            if (rise_c && win_cnt_q != CNT_MAX) win_cnt_q <= win_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_speed_level_meter.sv
// Self-checking bench for speed_level_meter: directed window table, boundary
// and abort sequences, then random windows against a window-level model.
module tb_speed_level_meter;

    localparam int GATE   = 40;
    localparam int CW     = 4;
    localparam int STEP   = 2;
    localparam int STOPW  = 2;
    localparam int CMAX   = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       wheel;
    logic [2:0] level;
    logic       moving;
    logic       valid;
    logic [CW-1:0] pulse_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    int m_zeros  = 0;
    int m_level  = 0;
    int m_carry  = 0;
    bit m_moving = 0;

    typedef struct {
        int npulse;
        bit boundary;
        int exp_cnt;
        int exp_level;
        bit exp_moving;
    } vec_t;

    vec_t vecs [8];

    speed_level_meter #(
        .GATE_CYCLES  (GATE),
        .CNT_W        (CW),
        .LEVEL_STEP   (STEP),
        .STOP_WINDOWS (STOPW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .wheel     (wheel),
        .level     (level),
        .moving    (moving),
        .valid     (valid),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Window-level reference: what the meter should report for a window that
    // contains n wheel rises, with a terminal-cycle rise carried forward.
    task automatic model_window(input int n, input bit boundary,
                                output int ecnt, output int elev, output bit emov);
        int raw;
        raw     = n + m_carry;
        m_carry = boundary ? 1 : 0;
        ecnt    = (raw > CMAX) ? CMAX : raw;
        if (ecnt > 0) begin
            m_level  = (ecnt / STEP > 7) ? 7 : ecnt / STEP;
            m_moving = 1;
            m_zeros  = 0;
        end else begin
            if (m_zeros < STOPW) m_zeros++;
            if (m_zeros == STOPW) begin
                m_moving = 0;
                m_level  = 0;
            end
        end
        elev = m_level;
        emov = m_moving;
    endtask

    // Drives one 40-cycle window starting just after the edge that opened it.
    // Rises sit at window-relative cycles 0..34; a boundary rise at 37 lands on
    // the terminal cycle after synchroniser latency.
    task automatic run_window(input int n, input bit boundary, input bit spread,
                              output int early);
        bit pat [GATE];
        int pos;
        int slack;
        int e;
        for (int r = 0; r < GATE; r++) pat[r] = 1'b0;
        pos   = 0;
        slack = (n > 0) ? 34 - 2 * (n - 1) : 0;
        for (int i = 0; i < n; i++) begin
            if (spread && slack > 0) begin
                e     = $urandom_range(slack, 0);
                pos   = pos + e;
                slack = slack - e;
            end
            pat[pos] = 1'b1;
            pos = pos + 2;
        end
        if (boundary) pat[37] = 1'b1;
        early = 0;
        for (int r = 0; r < GATE; r++) begin
            wheel = pat[r];
            step();
            if (r < GATE - 1 && valid) early++;
        end
        wheel = 1'b0;
    endtask

    task automatic do_window(input string name, input int n, input bit boundary,
                             input bit spread, input int ecnt, input int elev,
                             input bit emov);
        int early;
        run_window(n, boundary, spread, early);
        check({name, "_early_valid"}, early, 0);
        check({name, "_valid"}, int'(valid), 1);
        check({name, "_pulse_cnt"}, int'(pulse_cnt), ecnt);
        check({name, "_level"}, int'(level), elev);
        check({name, "_moving"}, int'(moving), int'(emov));
    endtask

    initial begin
        int ecnt;
        int elev;
        bit emov;
        int stray;
        int n;
        bit b;
        int early;
        bit pat [GATE];

        vecs[0] = '{5,  1'b0, 5,  2, 1'b1};
        vecs[1] = '{18, 1'b0, 15, 7, 1'b1};
        vecs[2] = '{6,  1'b0, 6,  3, 1'b1};
        vecs[3] = '{0,  1'b0, 0,  3, 1'b1};
        vecs[4] = '{0,  1'b0, 0,  0, 1'b0};
        vecs[5] = '{4,  1'b0, 4,  2, 1'b1};
        vecs[6] = '{0,  1'b1, 0,  2, 1'b1};
        vecs[7] = '{0,  1'b0, 1,  0, 1'b1};

        // Reset with wheel toggling and run asserted: reset must win.
        rst   = 1'b1;
        run   = 1'b1;
        wheel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wheel = ~wheel;
            step();
        end
        check("reset_level", int'(level), 0);
        check("reset_moving", int'(moving), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_pulse_cnt", int'(pulse_cnt), 0);

        // Idle with run low: outputs stay cleared.
        rst   = 1'b0;
        run   = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            wheel = (i < 8) ? ~wheel : 1'b0;
            step();
            if (valid || moving || level != 0 || pulse_cnt != 0) stray++;
        end
        check("idle_outputs_quiet", stray, 0);

        // Directed back-to-back windows.
        run = 1'b1;
        step();
        for (int v = 0; v < 8; v++) begin
            model_window(vecs[v].npulse, vecs[v].boundary, ecnt, elev, emov);
            do_window($sformatf("vec%0d", v), vecs[v].npulse, vecs[v].boundary, 1'b0,
                      vecs[v].exp_cnt, vecs[v].exp_level, vecs[v].exp_moving);
        end

        // Random windows against the model.
        for (int w = 0; w < 30; w++) begin
            n = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(18, 1);
            b = (w != 29) && ($urandom_range(5, 0) == 0);
            model_window(n, b, ecnt, elev, emov);
            do_window($sformatf("rand%0d", w), n, b, 1'b1, ecnt, elev, emov);
        end

        // Known nonzero window so the abort clear is observable.
        model_window(8, 1'b0, ecnt, elev, emov);
        do_window("pre_abort", 8, 1'b0, 1'b0, 8, 4, 1'b1);

        // Abort 15 cycles into a window holding 3 pulses.
        for (int r = 0; r < GATE; r++) pat[r] = 1'b0;
        pat[0] = 1'b1;
        pat[2] = 1'b1;
        pat[4] = 1'b1;
        early = 0;
        for (int r = 0; r < 14; r++) begin
            wheel = pat[r];
            step();
            if (valid) early++;
        end
        run   = 1'b0;
        wheel = 1'b0;
        step();
        check("abort_early_valid", early, 0);
        check("abort_valid", int'(valid), 0);
        check("abort_level", int'(level), 0);
        check("abort_moving", int'(moving), 0);
        check("abort_pulse_cnt", int'(pulse_cnt), 0);
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (valid || moving || level != 0 || pulse_cnt != 0) stray++;
        end
        check("abort_idle_quiet", stray, 0);

        // Fresh window after re-raising run.
        m_zeros  = 0;
        m_level  = 0;
        m_moving = 0;
        m_carry  = 0;
        run = 1'b1;
        step();
        model_window(3, 1'b0, ecnt, elev, emov);
        do_window("restart", 3, 1'b0, 1'b0, 3, 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
